// File: rtl/control_unit_pkg.sv
// Shared control-unit definitions: step encodings, opcode constants, ALU
// function codes and the one-hot instruction-class record produced by
// ctrl_decode. Also usable by the datapath ALU and by benches.
package control_unit_pkg;

   // Sequencer step: reset, fetch T0-T2, execute T3-T7, halted.
   typedef enum logic [3:0] {
      ST_RST  = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T2   = 4'd3,
      ST_T3   = 4'd4,
      ST_T4   = 4'd5,
      ST_T5   = 4'd6,
      ST_T6   = 4'd7,
      ST_T7   = 4'd8,
      ST_HALT = 4'd9
   } step_e;

   // Opcode field values (ir[IR_W-1:OPC_LSB]).
   localparam logic [4:0] OPC_LD   = 5'b00000;
   localparam logic [4:0] OPC_LDI  = 5'b00001;
   localparam logic [4:0] OPC_ST   = 5'b00010;
   localparam logic [4:0] OPC_ADD  = 5'b00011;
   localparam logic [4:0] OPC_SUB  = 5'b00100;
   localparam logic [4:0] OPC_AND  = 5'b00101;
   localparam logic [4:0] OPC_OR   = 5'b00110;
   localparam logic [4:0] OPC_ADDI = 5'b01100;
   localparam logic [4:0] OPC_IN   = 5'b10110;
   localparam logic [4:0] OPC_OUT  = 5'b10111;
   localparam logic [4:0] OPC_MFHI = 5'b11000;
   localparam logic [4:0] OPC_MFLO = 5'b11001;
   localparam logic [4:0] OPC_NOP  = 5'b11010;
   localparam logic [4:0] OPC_HALT = 5'b11011;

   // ALU function select codes.
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;

   // One-hot instruction class; exactly one field is set for any opcode.
   typedef struct packed {
      logic is_alu;
      logic is_imm;
      logic is_ldi;
      logic is_ld;
      logic is_st;
      logic is_in;
      logic is_out;
      logic is_mfhi;
      logic is_mflo;
      logic is_nop;
      logic is_halt;
      logic is_ill;
   } instr_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: 5-bit opcode -> one-hot instruction class
// plus the ALU function the execute phase should request.
module ctrl_decode
   import control_unit_pkg::*;
(
   input  logic [4:0]   opcode,
   output instr_class_t cls,
   output logic [3:0]   alu_fn
);

   // Classify opcode; anything not listed is flagged illegal.
   // NOTE: every output gets a default before the case so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      cls    = '0;
      alu_fn = ALU_ADD;
      case (opcode)
         OPC_ADD:  cls.is_alu = 1'b1;
         OPC_SUB:  begin cls.is_alu = 1'b1; alu_fn = ALU_SUB; end
         OPC_AND:  begin cls.is_alu = 1'b1; alu_fn = ALU_AND; end
         OPC_OR:   begin cls.is_alu = 1'b1; alu_fn = ALU_OR;  end
         OPC_ADDI: cls.is_imm  = 1'b1;
         OPC_LDI:  cls.is_ldi  = 1'b1;
         OPC_LD:   cls.is_ld   = 1'b1;
         OPC_ST:   cls.is_st   = 1'b1;
         OPC_IN:   cls.is_in   = 1'b1;
         OPC_OUT:  cls.is_out  = 1'b1;
         OPC_MFHI: cls.is_mfhi = 1'b1;
         OPC_MFLO: cls.is_mflo = 1'b1;
         OPC_NOP:  cls.is_nop  = 1'b1;
         OPC_HALT: cls.is_halt = 1'b1;
         default:  cls.is_ill  = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired sequencer: registered step state plus IR opcode decode drive all
// datapath strobes. Fetch is T0-T2, execute T3-T7, then back to T0.
// Optional feature macro CU_RUNSTOP_EN adds Stop/Run ports and the HALT
// state; without it the halt opcode behaves as nop.
module control_unit
   import control_unit_pkg::*;
#(
   parameter int IR_W    = 32,
   parameter int OPC_LSB = 27,
   parameter int ALU_W   = 4
) (
   input  logic             clock,
   input  logic             clear,
   input  logic [IR_W-1:0]  ir,
`ifdef CU_RUNSTOP_EN
   input  logic             Stop,
   output logic             Run,
`endif
   output logic             PCout,
   output logic             MARin,
   output logic             IncPC,
   output logic             PCin,
   output logic             Read,
   output logic             MDRin,
   output logic             MDRout,
   output logic             IRin,
   output logic             Yin,
   output logic             ZLowIn,
   output logic             ZLowOut,
   output logic             Write,
   output logic             Gra,
   output logic             Grb,
   output logic             Grc,
   output logic             Rin,
   output logic             Rout,
   output logic             BAout,
   output logic             RCout,
   output logic             HIout,
   output logic             LOout,
   output logic             InPortOut,
   output logic             OutPortIn,
   output logic [ALU_W-1:0] alu_op,
   output logic             illegal
);

   step_e        step_q, step_d;
   instr_class_t cls;
   logic [3:0]   alu_fn;
   logic         last_step;
   logic         unused_ir;

   // Only the opcode field matters here; the rest of ir feeds the datapath.
   assign unused_ir = ^ir[OPC_LSB-1:0];

   ctrl_decode u_decode (
      .opcode (ir[IR_W-1:OPC_LSB]),
      .cls    (cls),
      .alu_fn (alu_fn)
   );

   // Step register; clear forces RST immediately so every strobe drops at once.
   // NOTE: state flops use non-blocking assignment so all flops update together.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) step_q <= ST_RST;
      else       step_q <= step_d;
   end

   // Next-step logic: instruction length follows the decoded class.
   always_comb begin
      step_d    = step_q;
      last_step = 1'b0;
      case (step_q)
         ST_RST:  step_d = ST_T0;
         ST_T0:   step_d = ST_T1;
         ST_T1:   step_d = ST_T2;
         ST_T2:   step_d = ST_T3;
         ST_T3: begin
            if (cls.is_alu || cls.is_imm || cls.is_ldi || cls.is_ld || cls.is_st)
               step_d = ST_T4;
`ifdef CU_RUNSTOP_EN
            else if (cls.is_halt)
               step_d = ST_HALT;
`endif
            else
               last_step = 1'b1;
         end
         ST_T4:   step_d = ST_T5;
         ST_T5: begin
            if (cls.is_ld || cls.is_st) step_d = ST_T6;
            else                        last_step = 1'b1;
         end
         ST_T6:   step_d = ST_T7;
         ST_T7:   last_step = 1'b1;
         ST_HALT: step_d = ST_HALT;
         default: step_d = ST_RST;
      endcase
      if (last_step) begin
`ifdef CU_RUNSTOP_EN
         step_d = Stop ? ST_HALT : ST_T0;
`else
         step_d = ST_T0;
`endif
      end
   end

`ifdef CU_RUNSTOP_EN
   // Run reports an instruction in progress.
   assign Run = (step_q != ST_RST) && (step_q != ST_HALT);
`endif

   // Strobe decode from (step, class); RST, HALT and unused steps drive nothing.
   always_comb begin
      {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, ZLowIn,
       ZLowOut, Write, Gra, Grb, Grc, Rin, Rout, BAout, RCout, HIout, LOout,
       InPortOut, OutPortIn, illegal} = '0;
      alu_op = '0;
      case (step_q)
         ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
         ST_T1: begin ZLowOut = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
         ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
         ST_T3: begin
            if (cls.is_alu || cls.is_imm) begin
               Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
            end else if (cls.is_ldi || cls.is_ld || cls.is_st) begin
               Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
            end else if (cls.is_in) begin
               Gra = 1'b1; Rin = 1'b1; InPortOut = 1'b1;
            end else if (cls.is_out) begin
               Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1;
            end else if (cls.is_mfhi) begin
               Gra = 1'b1; Rin = 1'b1; HIout = 1'b1;
            end else if (cls.is_mflo) begin
               Gra = 1'b1; Rin = 1'b1; LOout = 1'b1;
            end else if (cls.is_ill) begin
               illegal = 1'b1;
            end
         end
         ST_T4: begin
            ZLowIn = 1'b1;
            alu_op = ALU_W'(alu_fn);
            if (cls.is_alu) begin Grc = 1'b1; Rout = 1'b1; end
            else            RCout = 1'b1;
         end
         ST_T5: begin
            ZLowOut = 1'b1;
            if (cls.is_ld || cls.is_st) MARin = 1'b1;
            else begin Gra = 1'b1; Rin = 1'b1; end
         end
         ST_T6: begin
            MDRin = 1'b1;
            if (cls.is_st) begin Gra = 1'b1; Rout = 1'b1; end
            else           Read = 1'b1;
         end
         ST_T7: begin
            if (cls.is_st) Write = 1'b1;
            else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class step by step
// against hand-built strobe vectors, checks clear mid-instruction, and (with
// CU_RUNSTOP_EN) the halt opcode and Stop behaviour. Bus-driver and
// Read/Write exclusivity are checked every cycle.
module tb_control_unit;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] ir;
`ifdef CU_RUNSTOP_EN
   logic        Stop;
   logic        Run;
`endif
   logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, ZLowIn;
   logic ZLowOut, Write, Gra, Grb, Grc, Rin, Rout, BAout, RCout, HIout, LOout;
   logic InPortOut, OutPortIn, illegal;
   logic [3:0] alu_op;

   int n_cmp = 0;
   int n_err = 0;

   // Bit positions of the observation vector {strobes, alu_op, illegal}.
   localparam logic [27:0] B_PCOUT   = 28'd1 << 27;
   localparam logic [27:0] B_MARIN   = 28'd1 << 26;
   localparam logic [27:0] B_INCPC   = 28'd1 << 25;
   localparam logic [27:0] B_PCIN    = 28'd1 << 24;
   localparam logic [27:0] B_READ    = 28'd1 << 23;
   localparam logic [27:0] B_MDRIN   = 28'd1 << 22;
   localparam logic [27:0] B_MDROUT  = 28'd1 << 21;
   localparam logic [27:0] B_IRIN    = 28'd1 << 20;
   localparam logic [27:0] B_YIN     = 28'd1 << 19;
   localparam logic [27:0] B_ZLOWIN  = 28'd1 << 18;
   localparam logic [27:0] B_ZLOWOUT = 28'd1 << 17;
   localparam logic [27:0] B_WRITE   = 28'd1 << 16;
   localparam logic [27:0] B_GRA     = 28'd1 << 15;
   localparam logic [27:0] B_GRB     = 28'd1 << 14;
   localparam logic [27:0] B_GRC     = 28'd1 << 13;
   localparam logic [27:0] B_RIN     = 28'd1 << 12;
   localparam logic [27:0] B_ROUT    = 28'd1 << 11;
   localparam logic [27:0] B_BAOUT   = 28'd1 << 10;
   localparam logic [27:0] B_RCOUT   = 28'd1 << 9;
   localparam logic [27:0] B_HIOUT   = 28'd1 << 8;
   localparam logic [27:0] B_LOOUT   = 28'd1 << 7;
   localparam logic [27:0] B_INPORT  = 28'd1 << 6;
   localparam logic [27:0] B_OUTPORT = 28'd1 << 5;
   localparam logic [27:0] A_SUB     = 28'h2;
   localparam logic [27:0] A_AND     = 28'h4;
   localparam logic [27:0] A_OR      = 28'h6;
   localparam logic [27:0] B_ILL     = 28'h1;

   localparam logic [27:0] F0 = B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN;
   localparam logic [27:0] F1 = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
   localparam logic [27:0] F2 = B_MDROUT | B_IRIN;
   localparam logic [27:0] E_RR_Y   = B_GRB | B_ROUT | B_YIN;
   localparam logic [27:0] E_BA_Y   = B_GRB | B_BAOUT | B_YIN;
   localparam logic [27:0] E_C_Z    = B_RCOUT | B_ZLOWIN;
   localparam logic [27:0] E_RC_Z   = B_GRC | B_ROUT | B_ZLOWIN;
   localparam logic [27:0] E_WB     = B_ZLOWOUT | B_GRA | B_RIN;

   logic [27:0] exp_ex [5];

   control_unit dut (
      .clock     (clock),
      .clear     (clear),
      .ir        (ir),
`ifdef CU_RUNSTOP_EN
      .Stop      (Stop),
      .Run       (Run),
`endif
      .PCout     (PCout),
      .MARin     (MARin),
      .IncPC     (IncPC),
      .PCin      (PCin),
      .Read      (Read),
      .MDRin     (MDRin),
      .MDRout    (MDRout),
      .IRin      (IRin),
      .Yin       (Yin),
      .ZLowIn    (ZLowIn),
      .ZLowOut   (ZLowOut),
      .Write     (Write),
      .Gra       (Gra),
      .Grb       (Grb),
      .Grc       (Grc),
      .Rin       (Rin),
      .Rout      (Rout),
      .BAout     (BAout),
      .RCout     (RCout),
      .HIout     (HIout),
      .LOout     (LOout),
      .InPortOut (InPortOut),
      .OutPortIn (OutPortIn),
      .alu_op    (alu_op),
      .illegal   (illegal)
   );

   always #5 clock = ~clock;

   function automatic logic [27:0] obs();
      return {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, ZLowIn,
              ZLowOut, Write, Gra, Grb, Grc, Rin, Rout, BAout, RCout, HIout,
              LOout, InPortOut, OutPortIn, alu_op, illegal};
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // Advance one clock; sample 1 time unit after the edge and check invariants.
   task automatic tick();
      int drivers;
      @(posedge clock);
      #1;
      drivers = $countones({PCout, ZLowOut, MDRout, Rout, BAout, RCout, HIout,
                            LOout, InPortOut});
      check("one_bus_driver", 32'(drivers <= 1), 32'd1);
      check("no_read_and_write", 32'(Read && Write), 32'd0);
   endtask

   // Run one instruction from T0 through its n execute steps (exp_ex[0..n-1]).
   task automatic run_instr(input string tag, input logic [31:0] v, input int n);
      ir = v;
      check({tag, "_t0"}, 32'(obs()), 32'(F0)); tick();
      check({tag, "_t1"}, 32'(obs()), 32'(F1)); tick();
      check({tag, "_t2"}, 32'(obs()), 32'(F2)); tick();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_t%0d", tag, i + 3), 32'(obs()), 32'(exp_ex[i]));
         tick();
      end
   endtask

   initial begin
      clear = 1'b1;
      ir    = 32'h0;
`ifdef CU_RUNSTOP_EN
      Stop  = 1'b0;
`endif
      #2;
      check("reset_outputs", 32'(obs()), 32'd0);
      tick(); tick();
      clear = 1'b0;
      #1;
      check("rst_cycle_outputs", 32'(obs()), 32'd0);
      tick();

      exp_ex = '{E_RR_Y, E_RC_Z, E_WB, 28'd0, 28'd0};
      run_instr("add", 32'h1889_8000, 3);
      exp_ex = '{E_RR_Y, E_RC_Z | A_SUB, E_WB, 28'd0, 28'd0};
      run_instr("sub", 32'h2089_8000, 3);
      exp_ex = '{E_RR_Y, E_RC_Z | A_AND, E_WB, 28'd0, 28'd0};
      run_instr("and", 32'h2889_8000, 3);
      exp_ex = '{E_RR_Y, E_RC_Z | A_OR, E_WB, 28'd0, 28'd0};
      run_instr("or", 32'h3089_8000, 3);
      exp_ex = '{E_RR_Y, E_C_Z, E_WB, 28'd0, 28'd0};
      run_instr("addi", 32'h6089_0007, 3);
      exp_ex = '{E_BA_Y, E_C_Z, E_WB, 28'd0, 28'd0};
      run_instr("ldi", 32'h0889_0005, 3);
      exp_ex = '{E_BA_Y, E_C_Z, B_ZLOWOUT | B_MARIN, B_READ | B_MDRIN,
                 B_MDROUT | B_GRA | B_RIN};
      run_instr("ld", 32'h0089_0065, 5);
      exp_ex = '{E_BA_Y, E_C_Z, B_ZLOWOUT | B_MARIN, B_GRA | B_ROUT | B_MDRIN,
                 B_WRITE};
      run_instr("st", 32'h1180_001F, 5);
      exp_ex[0] = B_GRA | B_RIN | B_INPORT;
      run_instr("in", 32'hB200_0000, 1);
      exp_ex[0] = B_GRA | B_ROUT | B_OUTPORT;
      run_instr("out", 32'hBA00_0000, 1);
      exp_ex[0] = B_GRA | B_RIN | B_HIOUT;
      run_instr("mfhi", 32'hC200_0000, 1);
      exp_ex[0] = B_GRA | B_RIN | B_LOOUT;
      run_instr("mflo", 32'hCA00_0000, 1);
      exp_ex[0] = 28'd0;
      run_instr("nop", 32'hD000_0000, 1);
      exp_ex[0] = B_ILL;
      run_instr("illegal", 32'hF800_0000, 1);
`ifndef CU_RUNSTOP_EN
      exp_ex[0] = 28'd0;
      run_instr("halt_as_nop", 32'hD800_0000, 1);
`endif
      check("back_to_t0", 32'(obs()), 32'(F0));

      // clear asserted in T6 of st: strobes drop at once, no Write follows.
      exp_ex = '{E_BA_Y, E_C_Z, B_ZLOWOUT | B_MARIN, 28'd0, 28'd0};
      run_instr("st_abort", 32'h1180_001F, 3);
      check("st_abort_t6", 32'(obs()), 32'(B_GRA | B_ROUT | B_MDRIN));
      clear = 1'b1;
      #1;
      check("clear_async", 32'(obs()), 32'd0);
      tick();
      check("clear_held", 32'(obs()), 32'd0);
      clear = 1'b0;
      #1;
      check("abort_rst_cycle", 32'(obs()), 32'd0);
      tick();
      check("abort_then_t0", 32'(obs()), 32'(F0));

`ifdef CU_RUNSTOP_EN
      check("run_in_t0", 32'(Run), 32'd1);
      exp_ex[0] = 28'd0;
      run_instr("halt", 32'hD800_0000, 1);
      for (int i = 0; i < 20; i++) begin
         check($sformatf("halt_outputs_%0d", i), 32'(obs()), 32'd0);
         check($sformatf("halt_run_%0d", i), 32'(Run), 32'd0);
         tick();
      end
      clear = 1'b1;
      tick();
      check("run_in_rst", 32'(Run), 32'd0);
      clear = 1'b0;
      tick();
      Stop = 1'b1;
      exp_ex = '{E_RR_Y, E_RC_Z, E_WB, 28'd0, 28'd0};
      run_instr("add_stop", 32'h1889_8000, 3);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("stop_outputs_%0d", i), 32'(obs()), 32'd0);
         check($sformatf("stop_run_%0d", i), 32'(Run), 32'd0);
         tick();
      end
      clear = 1'b1;
      tick();
      Stop  = 1'b0;
      clear = 1'b0;
      tick();
      check("restart_t0", 32'(obs()), 32'(F0));
      check("restart_run", 32'(Run), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
